// File: rtl/nal_pkg.sv
// Shared definitions for the Annex-B NAL packer.
//   START_CODE_LEN : bytes in the emitted start code (00 00 00 01)
//   EPB_BYTE       : emulation-prevention byte inserted into the payload
//   nal_state_e    : packer FSM states; each state names the byte held in the
//                    output register (StIdle: nothing held)
package nal_pkg;

    localparam int unsigned START_CODE_LEN = 4;
    localparam logic [7:0]  EPB_BYTE       = 8'h03;
    localparam logic [7:0]  SC_ZERO_BYTE   = 8'h00;
    localparam logic [7:0]  SC_ONE_BYTE    = 8'h01;

    typedef enum logic [2:0] {
        StIdle,
        StSc0,
        StSc1,
        StSc2,
        StSc3,
        StHdr,
        StData,
        StEpb
    } nal_state_e;

endpackage

// File: rtl/nal_byte_fifo.sv
// Synchronous byte FIFO for NAL payload bytes.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data (caller guarantees !full or rd_en in the same cycle)
//   wr_data    : byte to push
//   rd_en      : pop the head byte (caller guarantees !empty)
//   full/empty : occupancy flags
//   count      : occupancy, 0..FIFO_DEPTH
//   head       : byte at the FIFO head (valid when !empty)
module nal_byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               rd_en,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic [7:0]         head
);

    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_q <= count_q + 1'b1;
            end else if (!wr_en && rd_en) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/nal_ep_packer.sv
// Annex-B NAL packer: emits 00 00 00 01, the NAL header byte, then the
// payload with emulation-prevention bytes inserted.
//   clk, rst_n             : clock, asynchronous active-low reset
//   nal_start, nal_header  : begin a NAL (IDLE only), header byte latched with it
//   nal_end                : last payload byte delivered (or being delivered)
//   bs_valid_i, bs_i       : payload byte stream, no backpressure
//   out_valid, out_data    : registered output byte, held until out_ready
//   out_ready              : sink accepts out_data this cycle
//   busy_o                 : FSM not idle
//   nal_done               : one-cycle pulse once the NAL is fully emitted
//   ovf_o                  : sticky, a payload byte was dropped on a full FIFO
module nal_ep_packer
    import nal_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       nal_start,
    input  logic [7:0] nal_header,
    input  logic       nal_end,
    input  logic       bs_valid_i,
    input  logic [7:0] bs_i,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy_o,
    output logic       nal_done,
    output logic       ovf_o
);

    nal_state_e state_q, state_d;
    logic [7:0] hdr_q, hdr_d;
    logic [1:0] zero_cnt_q, zero_cnt_d;
    logic       end_pend_q, end_pend_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       nal_done_q, nal_done_d;
    logic       ovf_q, ovf_d;

    logic             fifo_wr;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic [7:0]       fifo_head;

    logic       out_free;
    logic       accept;
    logic       data_slot;
    logic [1:0] zc_eff;
    logic       need_epb;

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign fifo_wr = bs_valid_i && (!fifo_full || fifo_pop);

    nal_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (bs_i),
        .rd_en   (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    assign out_free = !out_valid_q || out_ready;
    assign accept   = out_valid_q && out_ready;
    // Zero run only counts payload bytes; leaving HDR or EPB restarts it.
    assign zc_eff   = (state_q == StData) ? zero_cnt_q : 2'd0;
    assign need_epb = (zc_eff == 2'd2) && (fifo_head[7:2] == 6'd0);

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        zero_cnt_d  = zero_cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        nal_done_d  = 1'b0;
        fifo_pop    = 1'b0;
        data_slot   = 1'b0;
        end_pend_d  = end_pend_q || (nal_end && ((state_q != StIdle) || nal_start));
        ovf_d       = ovf_q || (bs_valid_i && fifo_full && !fifo_pop);

        unique case (state_q)
            StIdle: begin
                if (nal_start) begin
                    hdr_d       = nal_header;
                    out_valid_d = 1'b1;
                    out_data_d  = SC_ZERO_BYTE;
                    state_d     = StSc0;
                end
            end
            StSc0: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = SC_ZERO_BYTE;
                    state_d     = StSc1;
                end
            end
            StSc1: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = SC_ZERO_BYTE;
                    state_d     = StSc2;
                end
            end
            StSc2: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = SC_ONE_BYTE;
                    state_d     = StSc3;
                end
            end
            StSc3: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hdr_q;
                    state_d     = StHdr;
                end
            end
            StHdr: begin
                if (accept) begin
                    zero_cnt_d = 2'd0;
                    state_d    = StData;
                    data_slot  = 1'b1;
                end
            end
            StData: begin
                if (out_free) begin
                    data_slot = 1'b1;
                    // A byte arriving this cycle must still go out before done.
                    if (fifo_empty && !bs_valid_i && end_pend_q) begin
                        nal_done_d = 1'b1;
                        end_pend_d = 1'b0;
                        zero_cnt_d = 2'd0;
                        state_d    = StIdle;
                    end
                end
            end
            StEpb: begin
                if (accept) begin
                    zero_cnt_d = 2'd0;
                    state_d    = StData;
                    data_slot  = 1'b1;
                end
            end
        endcase

        // Output register is free for a payload byte: either insert 0x03 in
        // front of the head byte (left in place) or move the head byte out.
        if (data_slot && !fifo_empty) begin
            out_valid_d = 1'b1;
            if (need_epb) begin
                out_data_d = EPB_BYTE;
                state_d    = StEpb;
            end else begin
                out_data_d = fifo_head;
                fifo_pop   = 1'b1;
                if (fifo_head == 8'h00) begin
                    zero_cnt_d = (zc_eff == 2'd0) ? 2'd1 : 2'd2;
                end else begin
                    zero_cnt_d = 2'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hdr_q       <= 8'h00;
            zero_cnt_q  <= 2'd0;
            end_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            nal_done_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            zero_cnt_q  <= zero_cnt_d;
            end_pend_q  <= end_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            nal_done_q  <= nal_done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign nal_done  = nal_done_q;
    assign ovf_o     = ovf_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_nal_ep_packer.sv
// Bench for nal_ep_packer: table of NAL vectors plus hand-written sequences
// for backpressure/overflow, nal_start while busy and reset mid-NAL.
module tb_nal_ep_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nal_start;
    logic [7:0] nal_header;
    logic       nal_end;
    logic       bs_valid_i;
    logic [7:0] bs_i;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy_o;
    logic       nal_done;
    logic       ovf_o;

    always #5 clk = ~clk;

    nal_ep_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nal_start  (nal_start),
        .nal_header (nal_header),
        .nal_end    (nal_end),
        .bs_valid_i (bs_valid_i),
        .bs_i       (bs_i),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy_o     (busy_o),
        .nal_done   (nal_done),
        .ovf_o      (ovf_o)
    );

    typedef struct packed {
        logic [7:0]   hdr;
        int           n;      // payload length
        logic [63:0]  pay;    // payload bytes, right-aligned, first byte leftmost
        int           pre;    // bytes written before nal_start
        logic         stall;  // toggle out_ready every cycle
        int           en;     // expected output length
        logic [127:0] exp;    // expected output bytes, right-aligned
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] got_q[$];
    int         done_cnt = 0;
    int         done_len = 0;
    logic       stall_mode = 1'b0;

    // Observe at the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (nal_done) begin
            done_cnt = done_cnt + 1;
            done_len = got_q.size();
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_mode) out_ready = ~out_ready;
    endtask

    function automatic logic [7:0] byte_at(input logic [127:0] v, input int n, input int i);
        return v[8*(n-1-i) +: 8];
    endfunction

    // Wait for nal_done, then compare the collected stream against exp.
    task automatic finish_nal(input string tag, input logic [127:0] exp, input int en);
        logic [31:0] g;
        for (int c = 0; c < 300 && done_cnt == 0; c++) tick();
        check({tag, " done pulses"}, 32'(done_cnt), 1);
        check({tag, " bytes before done"}, 32'(done_len), 32'(en));
        check({tag, " length"}, 32'(got_q.size()), 32'(en));
        for (int i = 0; i < en; i++) begin
            g = (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s byte%0d", tag, i), g, 32'(byte_at(exp, en, i)));
        end
        stall_mode = 1'b0;
        out_ready  = 1'b1;
        tick();
        check({tag, " busy after done"}, 32'(busy_o), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        got_q.delete();
        done_cnt   = 0;
        stall_mode = v.stall;
        out_ready  = 1'b1;
        for (int i = 0; i < v.pre; i++) begin
            bs_valid_i = 1'b1;
            bs_i       = byte_at({64'd0, v.pay}, v.n, i);
            tick();
        end
        nal_start  = 1'b1;
        nal_header = v.hdr;
        bs_valid_i = (v.pre < v.n);
        bs_i       = byte_at({64'd0, v.pay}, v.n, v.pre);
        nal_end    = (v.pre == v.n - 1);
        tick();
        nal_start = 1'b0;
        for (int i = v.pre + 1; i < v.n; i++) begin
            bs_valid_i = 1'b1;
            bs_i       = byte_at({64'd0, v.pay}, v.n, i);
            nal_end    = (i == v.n - 1);
            tick();
        end
        bs_valid_i = 1'b0;
        nal_end    = 1'b0;
        finish_nal(tag, v.exp, v.en);
    endtask

    vec_t        vecs [8];
    logic [31:0] e;

    initial begin
        vecs[0] = '{8'h65, 3, 64'h112280, 0, 1'b0, 8, 128'h00000001_65_112280};
        vecs[1] = '{8'h65, 3, 64'h000001, 0, 1'b0, 9, 128'h00000001_65_00000301};
        vecs[2] = '{8'h41, 3, 64'h000004, 0, 1'b0, 8, 128'h00000001_41_000004};
        vecs[3] = '{8'h41, 5, 64'h0000000001, 0, 1'b0, 12,
                    128'h00000001_41_00000300000301};
        vecs[4] = '{8'h00, 2, 64'h0001, 0, 1'b0, 7, 128'h00000001_00_0001};
        vecs[5] = '{8'h65, 6, 64'h000002000003, 0, 1'b0, 13,
                    128'h00000001_65_0000030200000303};
        vecs[6] = '{8'h65, 3, 64'h112280, 2, 1'b0, 8, 128'h00000001_65_112280};
        vecs[7] = '{8'h65, 6, 64'h000002000003, 0, 1'b1, 13,
                    128'h00000001_65_0000030200000303};

        rst_n      = 1'b0;
        nal_start  = 1'b0;
        nal_header = 8'h00;
        nal_end    = 1'b0;
        bs_valid_i = 1'b0;
        bs_i       = 8'h00;
        out_ready  = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out_data", 32'(out_data), 0);
        check("reset busy", 32'(busy_o), 0);
        check("reset nal_done", 32'(nal_done), 0);
        check("reset ovf", 32'(ovf_o), 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // nal_start while busy is ignored.
        got_q.delete();
        done_cnt   = 0;
        nal_start  = 1'b1;
        nal_header = 8'h65;
        bs_valid_i = 1'b1;
        bs_i       = 8'h11;
        tick();
        nal_start = 1'b0;
        bs_i      = 8'h22;
        tick();
        nal_start  = 1'b1;
        nal_header = 8'h99;
        bs_i       = 8'h80;
        nal_end    = 1'b1;
        tick();
        nal_start  = 1'b0;
        nal_end    = 1'b0;
        bs_valid_i = 1'b0;
        finish_nal("restart", 128'h00000001_65_112280, 8);
        repeat (10) tick();
        check("restart no 2nd start", 32'(got_q.size()), 8);
        check("restart idle valid", 32'(out_valid), 0);

        // Backpressure: 16 bytes fill the FIFO, the 17th is dropped.
        got_q.delete();
        done_cnt   = 0;
        out_ready  = 1'b0;
        nal_start  = 1'b1;
        nal_header = 8'h65;
        tick();
        nal_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bs_valid_i = 1'b1;
            bs_i       = 8'h10 + 8'(i);
            tick();
        end
        bs_valid_i = 1'b0;
        repeat (14) tick();
        check("bp ovf before 17th", 32'(ovf_o), 0);
        check("bp held valid", 32'(out_valid), 1);
        check("bp held data", 32'(out_data), 0);
        bs_valid_i = 1'b1;
        bs_i       = 8'hAA;
        tick();
        bs_valid_i = 1'b0;
        nal_end    = 1'b1;
        tick();
        nal_end = 1'b0;
        check("bp ovf after 17th", 32'(ovf_o), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 300 && done_cnt == 0; c++) tick();
        check("bp done pulses", 32'(done_cnt), 1);
        check("bp length", 32'(got_q.size()), 21);
        for (int i = 0; i < 21; i++) begin
            if (i < 3) e = 32'h00;
            else if (i == 3) e = 32'h01;
            else if (i == 4) e = 32'h65;
            else e = 32'h10 + 32'(i - 5);
            check($sformatf("bp byte%0d", i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, e);
        end
        check("bp ovf sticky", 32'(ovf_o), 1);

        // Reset mid-NAL after the header has gone out.
        got_q.delete();
        done_cnt   = 0;
        nal_start  = 1'b1;
        nal_header = 8'h65;
        tick();
        nal_start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bs_valid_i = 1'b1;
            bs_i       = 8'h31 + 8'(i);
            tick();
        end
        bs_valid_i = 1'b0;
        out_ready  = 1'b1;
        for (int c = 0; c < 50 && got_q.size() < 5; c++) tick();
        check("mid hdr emitted", 32'(got_q.size() >= 5), 1);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("mid rst out_valid", 32'(out_valid), 0);
        check("mid rst out_data", 32'(out_data), 0);
        check("mid rst busy", 32'(busy_o), 0);
        check("mid rst nal_done", 32'(nal_done), 0);
        check("mid rst ovf", 32'(ovf_o), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(vecs[0], "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
